mandelbrot_lanes: RTL and testbench
===================================

// Module: mandelbrot_lanes
// PURPOSE
//  Multi-lane Mandelbrot frame engine: scans a WIDTH x HEIGHT pixel grid, dispatches pixels round-robin to LANES
//  mandelbrot_alu instances, and emits per-pixel iteration counts strictly in raster order over a valid/ready stream.
//  Sits between the register/config front end and the display/pixel sink.
//  Adds lane parallelism, a backpressured output stream, latched per-frame config and abort.
// PARAMETERS
//  BITWIDTH  10   fixed-point width of c/z values (passed to each mandelbrot_alu as WIDTH)
//  CTRWIDTH  7    iteration counter width
//  LANES     2    number of parallel ALU lanes (1..8)
//  WIDTH     320  pixels per line
//  HEIGHT    240  lines per frame
// PORTS
//  clk        in   1                clock, all logic on rising edge
//  rst_n      in   1                synchronous active-low reset
//  run        in   1                start a frame (sampled only in STOP)
//  abort      in   1                synchronous frame abort (any state)
//  running    out  1                high in SCAN or DRAIN
//  max_ctr    in   CTRWIDTH         iteration limit
//  ctr_select in   $clog2(CTRWIDTH) LSB position of 4-bit count window
//  scaling    in   7                pixel step minus one
//  cr_offset  in   BITWIDTH         real part of pixel (0,0)
//  ci_offset  in   BITWIDTH         imaginary part of pixel (0,0)
//  pix_valid  out  1                pixel result available
//  pix_ready  in   1                sink accepts pixel
//  pix_ctr    out  4                windowed iteration count
//  pix_x      out  $clog2(WIDTH)    pixel column
//  pix_y      out  $clog2(HEIGHT)   pixel row
//  pix_last   out  1                pixel is (WIDTH-1,HEIGHT-1)
//  frame_done out  1                one-cycle pulse when last pixel accepted
// BEHAVIOUR
//  Reset: state STOP; running, pix_valid, pix_last, frame_done = 0; pix_ctr, pix_x, pix_y = 0; all lanes IDLE.
//  Top FSM: STOP --run&!abort--> SCAN --last pixel dispatched--> DRAIN --last pixel handshake--> STOP.
//   abort in SCAN/DRAIN (or rst_n low) -> STOP next cycle; lanes IDLE, pix_valid 0, no frame_done; abort wins over run.
//  On run in STOP: latch max_ctr, ctr_select, scaling, cr_offset, ci_offset; input changes mid-frame have no effect.
//  Coordinates: step = {zero-extend scaling}+1; cr += step per column; at x==WIDTH-1: x=0, cr=cr_offset, y++, ci += step.
//   All c arithmetic wraps modulo 2^BITWIDTH.
//  Dispatch: pointer dp cycles 0..LANES-1; in SCAN, if lane dp IDLE, load it with (x,y,cr,ci), z=0, ctr=0,
//   pulse its alu start next cycle; advance dp and coordinates. At most one dispatch per cycle.
//  Lane FSM IDLE -> ITER -> DONE -> IDLE. In ITER, on alu finished: if size | overflowed | ctr==max_ctr -> DONE
//   holding ctr; else z<=out_z, ctr++, overflowed<=overflow, restart alu next cycle.
//  Retire: pointer rp cycles 0..LANES-1; pix_valid = lane rp in DONE; lane results never reorder.
//   Handshake on pix_valid&pix_ready: lane rp -> IDLE, rp advances; a lane freed this cycle may be redispatched next cycle.
//   pix_valid held and pix_* stable until accepted (AXI-style, no drop, no combinational ready->valid path).
//  pix_ctr = ctr[ctr_select+3 : ctr_select]; bits at index >= CTRWIDTH read as 0; ctr_select >= CTRWIDTH -> 0.
//  max_ctr==0: each pixel retires after its first ALU completion with ctr 0.
//  frame_done asserted the cycle after the pix_last handshake, coincident with running falling.
// TESTING
//  LANES=2, WIDTH=4, HEIGHT=2, max_ctr=0, pix_ready=1, run pulse -> 8 pixels (0,0)..(3,1) raster order, all pix_ctr=0,
//   pix_last only on 8th, one frame_done pulse, running low after.
//  cr_offset=ci_offset=0, scaling=127, max_ctr=20, ctr_select=2 -> pixel (0,0) pix_ctr=5 (c=0 never escapes).
//  pix_ready=0 for 200 cycles after run -> pix_valid stays 1 at (0,0), pix_* stable, exactly LANES pixels dispatched.
//  abort 10 cycles into SCAN -> STOP next cycle, pix_valid=0, no frame_done; new run restarts at (0,0) with fresh config.
//  Change cr_offset/scaling mid-frame -> frame results identical to an unchanged reference frame.
//  rst_n=0 for one cycle mid-DRAIN -> all outputs at reset values next cycle; run still ignored while rst_n low.

Source files
------------

// File: rtl/mandelbrot_lanes_if.sv
// Pixel result stream between the Mandelbrot frame engine and the pixel sink.
//   pix_valid : result available (source)
//   pix_ready : sink accepts the current result (sink)
//   pix_ctr   : 4-bit windowed iteration count
//   pix_x/y   : pixel column / row
//   pix_last  : pixel is the last one of the frame
// master = engine side, slave = sink side.
interface mandelbrot_lanes_if #(
    parameter int XW = 9,
    parameter int YW = 8
) ();
    logic          pix_valid;
    logic          pix_ready;
    logic [3:0]    pix_ctr;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_last;

    modport master (
        output pix_valid, pix_ctr, pix_x, pix_y, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_ctr, pix_x, pix_y, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/mandelbrot_lanes.sv
// Multi-lane Mandelbrot frame engine.
// Scans a WIDTH x HEIGHT grid, hands pixels round-robin to LANES iteration
// units and streams the iteration counts back out in raster order.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   run, abort            start a frame (in STOP) / abandon the current frame
//   running               frame in progress (SCAN or DRAIN)
//   max_ctr, ctr_select   iteration limit, LSB of the 4-bit count window
//   scaling               pixel step minus one
//   cr_offset, ci_offset  complex value of pixel (0,0)
//   pix                   result stream (mandelbrot_lanes_if.master)
//   frame_done            one-cycle pulse after the last pixel is accepted
//
// Top FSM
//   state | meaning
//   STOP  | idle, waiting for run
//   SCAN  | walking the grid and dispatching pixels to lanes
//   DRAIN | every pixel dispatched, waiting for the remaining results

// One Mandelbrot iteration z' = z^2 + c on signed fixed point with WIDTH-3
// fractional bits. Results appear one cycle after start. size reports
// |z|^2 > 4 for the input z; overflow reports that z' did not fit in WIDTH.
module mandelbrot_alu #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] cr,
    input  logic [WIDTH-1:0] ci,
    input  logic [WIDTH-1:0] zr,
    input  logic [WIDTH-1:0] zi,
    output logic             finished,
    output logic [WIDTH-1:0] out_zr,
    output logic [WIDTH-1:0] out_zi,
    output logic             size,
    output logic             overflow
);
    localparam int F  = WIDTH - 3;
    localparam int EW = 2 * WIDTH + 2;
    localparam logic signed [EW-1:0] FOUR = EW'(4) <<< F;
    localparam logic signed [EW-1:0] MAXV = (EW'(1) <<< (WIDTH - 1)) - EW'(1);
    localparam logic signed [EW-1:0] MINV = -(EW'(1) <<< (WIDTH - 1));

    logic signed [EW-1:0] ezr, ezi, ecr, eci;
    logic signed [EW-1:0] zr2, zi2, zxy2, mag, nzr, nzi;

    always_comb begin
        ezr  = EW'($signed(zr));
        ezi  = EW'($signed(zi));
        ecr  = EW'($signed(cr));
        eci  = EW'($signed(ci));
        zr2  = (ezr * ezr) >>> F;
        zi2  = (ezi * ezi) >>> F;
        // 2*zr*zi folded into the shift
        zxy2 = (ezr * ezi) >>> (F - 1);
        mag  = zr2 + zi2;
        nzr  = zr2 - zi2 + ecr;
        nzi  = zxy2 + eci;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            finished <= 1'b0;
            out_zr   <= '0;
            out_zi   <= '0;
            size     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            finished <= start;
            if (start) begin
                out_zr   <= nzr[WIDTH-1:0];
                out_zi   <= nzi[WIDTH-1:0];
                size     <= (mag > FOUR);
                overflow <= (nzr > MAXV) || (nzr < MINV) || (nzi > MAXV) || (nzi < MINV);
            end
        end
    end
endmodule

module mandelbrot_lanes #(
    parameter int BITWIDTH = 10,
    parameter int CTRWIDTH = 7,
    parameter int LANES    = 2,
    parameter int WIDTH    = 320,
    parameter int HEIGHT   = 240
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic                        abort,
    output logic                        running,
    input  logic [CTRWIDTH-1:0]         max_ctr,
    input  logic [$clog2(CTRWIDTH)-1:0] ctr_select,
    input  logic [6:0]                  scaling,
    input  logic [BITWIDTH-1:0]         cr_offset,
    input  logic [BITWIDTH-1:0]         ci_offset,
    mandelbrot_lanes_if.master          pix,
    output logic                        frame_done
);
    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = $clog2(HEIGHT);
    localparam int SW   = $clog2(CTRWIDTH);
    localparam int DPW  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {STOP = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} top_state_t;
    typedef enum logic [1:0] {L_IDLE = 2'd0, L_ITER = 2'd1, L_DONE = 2'd2} lane_state_t;

    top_state_t state, state_nx;

    // frame configuration, captured when a frame starts
    logic [CTRWIDTH-1:0] cfg_max;
    logic [SW-1:0]       cfg_sel;
    logic [BITWIDTH-1:0] cfg_step;
    logic [BITWIDTH-1:0] cfg_cr0;

    // scan position of the next pixel to dispatch
    logic [XW-1:0]       scan_x;
    logic [YW-1:0]       scan_y;
    logic [BITWIDTH-1:0] scan_cr;
    logic [BITWIDTH-1:0] scan_ci;
    logic [DPW-1:0]      dp;
    logic [DPW-1:0]      rp;

    lane_state_t         lane_st  [LANES];
    logic [XW-1:0]       lane_x   [LANES];
    logic [YW-1:0]       lane_y   [LANES];
    logic [BITWIDTH-1:0] lane_cr  [LANES];
    logic [BITWIDTH-1:0] lane_ci  [LANES];
    logic [BITWIDTH-1:0] lane_zr  [LANES];
    logic [BITWIDTH-1:0] lane_zi  [LANES];
    logic [CTRWIDTH-1:0] lane_ctr [LANES];
    logic [LANES-1:0]    lane_ovf;
    logic [LANES-1:0]    lane_start;

    logic [LANES-1:0]    alu_fin;
    logic [LANES-1:0]    alu_size;
    logic [LANES-1:0]    alu_ovf;
    logic [BITWIDTH-1:0] alu_zr [LANES];
    logic [BITWIDTH-1:0] alu_zi [LANES];

    logic start_frame, dispatch, last_xy, out_valid, out_last, hs;
    logic [CTRWIDTH+3:0] ctr_shifted;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mandelbrot_alu #(.WIDTH(BITWIDTH)) u_alu (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (lane_start[g]),
            .cr       (lane_cr[g]),
            .ci       (lane_ci[g]),
            .zr       (lane_zr[g]),
            .zi       (lane_zi[g]),
            .finished (alu_fin[g]),
            .out_zr   (alu_zr[g]),
            .out_zi   (alu_zi[g]),
            .size     (alu_size[g]),
            .overflow (alu_ovf[g])
        );
    end

    assign start_frame = (state == STOP) && run && !abort;
    assign dispatch    = (state == SCAN) && !abort && (lane_st[dp] == L_IDLE);
    assign last_xy     = (scan_x == XW'(WIDTH - 1)) && (scan_y == YW'(HEIGHT - 1));
    assign out_valid   = (lane_st[rp] == L_DONE);
    assign out_last    = out_valid && (lane_x[rp] == XW'(WIDTH - 1))
                                   && (lane_y[rp] == YW'(HEIGHT - 1));
    assign hs          = out_valid && pix.pix_ready;
    assign running     = (state != STOP);

    // zero-padded right shift: window bits past the counter width read as 0
    assign ctr_shifted   = {4'b0, lane_ctr[rp]} >> cfg_sel;
    assign pix.pix_valid = out_valid;
    assign pix.pix_ctr   = ctr_shifted[3:0];
    assign pix.pix_x     = lane_x[rp];
    assign pix.pix_y     = lane_y[rp];
    assign pix.pix_last  = out_last;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= STOP;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            STOP:  if (run && !abort) state_nx = SCAN;
            SCAN:  if (abort) state_nx = STOP;
                   else if (dispatch && last_xy) state_nx = DRAIN;
            DRAIN: if (abort) state_nx = STOP;
                   else if (hs && out_last) state_nx = STOP;
            default: state_nx = STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            cfg_max    <= '0;
            cfg_sel    <= '0;
            cfg_step   <= '0;
            cfg_cr0    <= '0;
            scan_x     <= '0;
            scan_y     <= '0;
            scan_cr    <= '0;
            scan_ci    <= '0;
            dp         <= '0;
            rp         <= '0;
            lane_ovf   <= '0;
            lane_start <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_st[i]  <= L_IDLE;
                lane_x[i]   <= '0;
                lane_y[i]   <= '0;
                lane_cr[i]  <= '0;
                lane_ci[i]  <= '0;
                lane_zr[i]  <= '0;
                lane_zi[i]  <= '0;
                lane_ctr[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                dp         <= '0;
                rp         <= '0;
                lane_start <= '0;
                for (int i = 0; i < LANES; i++) lane_st[i] <= L_IDLE;
            end else begin
                if (start_frame) begin
                    cfg_max  <= max_ctr;
                    cfg_sel  <= ctr_select;
                    cfg_step <= BITWIDTH'(scaling) + BITWIDTH'(1);
                    cfg_cr0  <= cr_offset;
                    scan_x   <= '0;
                    scan_y   <= '0;
                    scan_cr  <= cr_offset;
                    scan_ci  <= ci_offset;
                    dp       <= '0;
                    rp       <= '0;
                end

                if (dispatch) begin
                    dp <= (dp == DPW'(LANES - 1)) ? '0 : dp + DPW'(1);
                    if (scan_x == XW'(WIDTH - 1)) begin
                        scan_x  <= '0;
                        scan_cr <= cfg_cr0;
                        scan_y  <= scan_y + YW'(1);
                        scan_ci <= scan_ci + cfg_step;
                    end else begin
                        scan_x  <= scan_x + XW'(1);
                        scan_cr <= scan_cr + cfg_step;
                    end
                end

                if (hs) begin
                    rp <= (rp == DPW'(LANES - 1)) ? '0 : rp + DPW'(1);
                    if (out_last) frame_done <= 1'b1;
                end

                for (int i = 0; i < LANES; i++) begin
                    lane_start[i] <= 1'b0;
                    unique case (lane_st[i])
                        L_IDLE: begin
                            if (dispatch && (dp == DPW'(i))) begin
                                lane_st[i]    <= L_ITER;
                                lane_x[i]     <= scan_x;
                                lane_y[i]     <= scan_y;
                                lane_cr[i]    <= scan_cr;
                                lane_ci[i]    <= scan_ci;
                                lane_zr[i]    <= '0;
                                lane_zi[i]    <= '0;
                                lane_ctr[i]   <= '0;
                                lane_ovf[i]   <= 1'b0;
                                lane_start[i] <= 1'b1;
                            end
                        end
                        L_ITER: begin
                            if (alu_fin[i]) begin
                                // overflow flag lags one iteration: it marks z as
                                // already corrupt when the next result comes back
                                if (alu_size[i] || lane_ovf[i] || (lane_ctr[i] == cfg_max)) begin
                                    lane_st[i] <= L_DONE;
                                end else begin
                                    lane_zr[i]    <= alu_zr[i];
                                    lane_zi[i]    <= alu_zi[i];
                                    lane_ctr[i]   <= lane_ctr[i] + CTRWIDTH'(1);
                                    lane_ovf[i]   <= alu_ovf[i];
                                    lane_start[i] <= 1'b1;
                                end
                            end
                        end
                        L_DONE: begin
                            if (hs && (rp == DPW'(i))) lane_st[i] <= L_IDLE;
                        end
                        default: lane_st[i] <= L_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_mandelbrot_lanes.sv
// Self-checking bench for mandelbrot_lanes (LANES=2, 4x2 frame).
// Expected pixels come from an escape-time reference model and are queued
// when a frame is started; a negedge monitor pops and compares on handshake.
module tb_mandelbrot_lanes;
    logic       clk = 1'b0;
    logic       rst_n, run, abort, running, frame_done;
    logic [6:0] max_ctr;
    logic [2:0] ctr_select;
    logic [6:0] scaling;
    logic [9:0] cr_offset, ci_offset;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int ctr00    = -1;

    typedef struct packed {
        logic [1:0] x;
        logic       y;
        logic [3:0] ctr;
        logic       last;
    } exp_t;
    exp_t sb[$];

    mandelbrot_lanes_if #(.XW(2), .YW(1)) pif ();

    mandelbrot_lanes #(
        .BITWIDTH(10), .CTRWIDTH(7), .LANES(2), .WIDTH(4), .HEIGHT(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .abort      (abort),
        .running    (running),
        .max_ctr    (max_ctr),
        .ctr_select (ctr_select),
        .scaling    (scaling),
        .cr_offset  (cr_offset),
        .ci_offset  (ci_offset),
        .pix        (pif.master),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        int w;
        w = v & 1023;
        return (w >= 512) ? w - 1024 : w;
    endfunction

    // escape-time reference on Q3.7 values
    function automatic int mandel(input int cr, input int ci, input int mx);
        int zr, zi, ctr, a, b, c, nr, ni;
        bit ovf, sz, o;
        zr = 0; zi = 0; ctr = 0; ovf = 0;
        for (int k = 0; k < 300; k++) begin
            a  = (zr * zr) >>> 7;
            b  = (zi * zi) >>> 7;
            c  = (zr * zi) >>> 6;
            sz = (a + b) > 512;
            nr = a - b + sx(cr);
            ni = c + sx(ci);
            o  = (nr > 511) || (nr < -512) || (ni > 511) || (ni < -512);
            if (sz || ovf || ctr == mx) return ctr;
            zr = sx(nr);
            zi = sx(ni);
            ctr++;
            ovf = o;
        end
        return ctr;
    endfunction

    task automatic push_frame(input int cr0, input int ci0, input int scal, input int mx, input int sel);
        int   step, cnt;
        exp_t e;
        step = scal + 1;
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                cnt    = mandel((cr0 + x * step) & 1023, (ci0 + y * step) & 1023, mx);
                e.x    = 2'(x);
                e.y    = 1'(y);
                e.ctr  = 4'((cnt >> sel) & 15);
                e.last = (x == 3) && (y == 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int cr0, input int ci0, input int scal, input int mx, input int sel);
        cr_offset  = 10'(cr0);
        ci_offset  = 10'(ci0);
        scaling    = 7'(scal);
        max_ctr    = 7'(mx);
        ctr_select = 3'(sel);
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int budget);
        int f0, n;
        f0 = fd_cnt;
        n  = 0;
        while (fd_cnt == f0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(fd_cnt - f0), 1);
        check({tag, "_run_low"}, 32'(running), 0);
        repeat (4) tick();
        check({tag, "_one_pulse"}, 32'(fd_cnt - f0), 1);
        check({tag, "_sb_empty"}, 32'(sb.size()), 0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_running"}, 32'(running), 0);
        check({tag, "_valid"}, 32'(pif.pix_valid), 0);
        check({tag, "_last"}, 32'(pif.pix_last), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_ctr"}, 32'(pif.pix_ctr), 0);
        check({tag, "_x"}, 32'(pif.pix_x), 0);
        check({tag, "_y"}, 32'(pif.pix_y), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (frame_done === 1'b1) fd_cnt++;
        if (pif.pix_valid === 1'b1 && pif.pix_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pixel", 32'(pif.pix_valid), 0);
            end else begin
                e = sb.pop_front();
                check("pix_x", 32'(pif.pix_x), 32'(e.x));
                check("pix_y", 32'(pif.pix_y), 32'(e.y));
                check("pix_ctr", 32'(pif.pix_ctr), 32'(e.ctr));
                check("pix_last", 32'(pif.pix_last), 32'(e.last));
                if (pif.pix_x == 2'd0 && pif.pix_y == 1'b0) ctr00 = int'(pif.pix_ctr);
            end
        end
    end

    initial begin
        int f0, bad, n;
        rst_n = 1'b0; run = 1'b0; abort = 1'b0;
        pif.pix_ready = 1'b1;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // basic frame, max_ctr 0
        set_cfg(100, 700, 5, 0, 0);
        push_frame(100, 700, 5, 0, 0);
        start_run();
        check("running_after_run", 32'(running), 1);
        wait_frame("basic", 500);

        // c = 0 at (0,0) never escapes
        ctr00 = -1;
        set_cfg(0, 0, 127, 20, 2);
        push_frame(0, 0, 127, 20, 2);
        start_run();
        wait_frame("c0", 3000);
        check("c0_pixel00_ctr", 32'(ctr00), 5);

        // backpressure: only LANES pixels dispatched, head pixel held stable
        pif.pix_ready = 1'b0;
        set_cfg(0, 0, 127, 3, 0);
        push_frame(0, 0, 127, 3, 0);
        start_run();
        repeat (10) tick();
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (pif.pix_valid !== 1'b1 || pif.pix_x !== 2'd0 || pif.pix_y !== 1'b0 ||
                pif.pix_ctr !== 4'd3) bad++;
            tick();
        end
        check("bp_hold", 32'(bad), 0);
        check("bp_dispatched", 32'(dut.scan_x), 2);
        check("bp_scan_y", 32'(dut.scan_y), 0);
        pif.pix_ready = 1'b1;
        wait_frame("bp", 2000);

        // abort mid-SCAN, then restart with fresh config
        set_cfg(0, 0, 127, 20, 2);
        push_frame(0, 0, 127, 20, 2);
        start_run();
        repeat (10) tick();
        f0 = fd_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_running", 32'(running), 0);
        check("abort_valid", 32'(pif.pix_valid), 0);
        sb.delete();
        repeat (20) tick();
        check("abort_no_done", 32'(fd_cnt - f0), 0);
        check("abort_stay_stop", 32'(running), 0);
        set_cfg(300, 50, 9, 0, 0);
        push_frame(300, 50, 9, 0, 0);
        start_run();
        wait_frame("restart", 500);

        // config changes mid-frame must not affect the frame in flight
        set_cfg(900, 1000, 40, 30, 0);
        push_frame(900, 1000, 40, 30, 0);
        start_run();
        repeat (5) tick();
        set_cfg(0, 200, 3, 5, 3);
        wait_frame("midchg", 3000);

        // synchronous reset during DRAIN; run ignored while held
        set_cfg(0, 0, 127, 127, 0);
        push_frame(0, 0, 127, 127, 0);
        start_run();
        n = 0;
        while (dut.state !== 2'd2 && n < 5000) begin
            tick();
            n++;
        end
        check("reached_drain", 32'(dut.state), 2);
        f0 = fd_cnt;
        rst_n = 1'b0;
        run   = 1'b1;
        tick();
        check_reset_outputs("rst_drain");
        rst_n = 1'b1;
        run   = 1'b0;
        sb.delete();
        tick();
        check("rst_run_ignored", 32'(running), 0);
        repeat (10) tick();
        check("rst_no_done", 32'(fd_cnt - f0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
